// File: rtl/writeback_queue_pkg.sv
// Shared types for the writeback queue (package scc_wb_pkg).
// Optional feature macro used elsewhere in this slice: WB_FORWARD_EN.
package scc_wb_pkg;

    localparam int WB_DEPTH  = 4;
    localparam int WB_ADDR_W = 3;
    localparam int WB_DATA_W = 32;

    localparam logic SRC_ALU = 1'b1;
    localparam logic SRC_ID  = 1'b0;

    typedef struct packed {
        logic                 src;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] value;
    } wb_entry_t;

    function automatic wb_entry_t make_entry(input logic                 src,
                                             input logic [WB_ADDR_W-1:0] addr,
                                             input logic [WB_DATA_W-1:0] value);
        wb_entry_t e;
        e.src   = src;
        e.addr  = addr;
        e.value = value;
        return e;
    endfunction

endpackage

// File: rtl/writeback_queue_if.sv
// Bus between producers (ALU, ID), the register file write port and issue logic.
// Handshake: a producer holds X_valid with its payload; the transfer happens on the
// rising edge where X_valid && X_ready. Valid never waits on ready; ready depends only
// on queue state and alu_valid. fwd_* is meaningful only when WB_FORWARD_EN is defined.
interface writeback_queue_if #(parameter int DEPTH = scc_wb_pkg::WB_DEPTH);
    import scc_wb_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                    alu_valid;
    logic [WB_ADDR_W-1:0]    alu_addr;
    logic [WB_DATA_W-1:0]    alu_value;
    logic                    alu_ready;
    logic                    id_valid;
    logic [WB_ADDR_W-1:0]    id_addr;
    logic [WB_DATA_W-1:0]    id_value;
    logic                    id_ready;
    logic [WB_ADDR_W-1:0]    write_addr;
    logic [WB_DATA_W-1:0]    write_value_alu;
    logic [WB_DATA_W-1:0]    write_value_id;
    logic                    write_data_sel;
    logic                    write_enable;
    logic [2**WB_ADDR_W-1:0] pending_mask;
    logic [CNT_W-1:0]        occupancy;
    logic [WB_ADDR_W-1:0]    fwd_addr;
    logic                    fwd_hit;
    logic [WB_DATA_W-1:0]    fwd_value;

    modport slave (
        input  alu_valid, alu_addr, alu_value, id_valid, id_addr, id_value, fwd_addr,
        output alu_ready, id_ready, write_addr, write_value_alu, write_value_id,
               write_data_sel, write_enable, pending_mask, occupancy, fwd_hit, fwd_value
    );

    modport master (
        output alu_valid, alu_addr, alu_value, id_valid, id_addr, id_value, fwd_addr,
        input  alu_ready, id_ready, write_addr, write_value_alu, write_value_id,
               write_data_sel, write_enable, pending_mask, occupancy, fwd_hit, fwd_value
    );

endinterface

// File: rtl/writeback_queue_fifo.sv
// Circular store with two push ports (A older than B within a cycle) and one pop.
// The head pops automatically whenever the queue is non-empty.
module wb_dual_push_fifo
    import scc_wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_a_i,
    input  wb_entry_t                  entry_a_i,
    input  logic                       push_b_i,
    input  wb_entry_t                  entry_b_i,
    output wb_entry_t                  head_o,
    output logic                       head_valid_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr_o,
    output logic [DEPTH-1:0]           valid_o,
    output wb_entry_t                  entries_o [DEPTH]
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] slot_a, slot_b;
    logic             pop;

    // Next-state: B lands behind A; a slot popped this edge may be refilled this edge.
    always_comb begin
        pop      = (count_q != '0);
        slot_a   = wr_ptr_q;
        slot_b   = wr_ptr_q + PTR_W'(push_a_i);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_a_i) + PTR_W'(push_b_i);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push_a_i) + CNT_W'(push_b_i) - CNT_W'(pop);
        valid_d  = valid_q;
        if (pop)      valid_d[rd_ptr_q] = 1'b0;
        if (push_a_i) valid_d[slot_a]   = 1'b1;
        if (push_b_i) valid_d[slot_b]   = 1'b1;
    end

    // Control state; reset flushes everything and drops that cycle's pushes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage; contents are meaningless where the valid bit is clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (push_a_i) mem_q[slot_a] <= entry_a_i;
            if (push_b_i) mem_q[slot_b] <= entry_b_i;
        end
    end

    assign head_o       = mem_q[rd_ptr_q];
    assign head_valid_o = (count_q != '0);
    assign count_o      = count_q;
    assign rd_ptr_o     = rd_ptr_q;
    assign valid_o      = valid_q;
    assign entries_o    = mem_q;

endmodule

// File: rtl/writeback_queue.sv
// Writeback queue in front of the 8x32 register file write port.
// Optional feature: define WB_FORWARD_EN to enable the fwd_addr lookup (youngest match).
module writeback_queue
    import scc_wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    writeback_queue_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t          head;
    logic               head_valid;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   rd_ptr;
    logic [DEPTH-1:0]   valid;
    wb_entry_t          entries [DEPTH];
    logic [CNT_W:0]     free;
    logic               push_a, push_b;

    // Slots available this cycle; the head always pops, so it counts as free.
    always_comb begin
        free = (CNT_W+1)'(DEPTH) - {1'b0, count} + (CNT_W+1)'(count != '0);
        bus.alu_ready = (free >= (CNT_W+1)'(1));
        bus.id_ready  = bus.alu_valid ? (free >= (CNT_W+1)'(2)) : (free >= (CNT_W+1)'(1));
        push_a = bus.alu_valid & bus.alu_ready;
        push_b = bus.id_valid & bus.id_ready;
    end

    wb_dual_push_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_a_i     (push_a),
        .entry_a_i    (make_entry(SRC_ALU, bus.alu_addr, bus.alu_value)),
        .push_b_i     (push_b),
        .entry_b_i    (make_entry(SRC_ID, bus.id_addr, bus.id_value)),
        .head_o       (head),
        .head_valid_o (head_valid),
        .count_o      (count),
        .rd_ptr_o     (rd_ptr),
        .valid_o      (valid),
        .entries_o    (entries)
    );

    // Register-file write port decoded from the registered head; zero when empty.
    always_comb begin
        bus.write_enable    = head_valid;
        bus.write_addr      = head_valid ? head.addr : '0;
        bus.write_data_sel  = head_valid & (head.src == SRC_ALU);
        bus.write_value_alu = (head_valid && head.src == SRC_ALU) ? head.value : '0;
        bus.write_value_id  = (head_valid && head.src == SRC_ID)  ? head.value : '0;
        bus.occupancy       = count;
    end

    // Pending mask: one bit per destination register with a queued write.
    always_comb begin
        bus.pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) bus.pending_mask[entries[i].addr] = 1'b1;
        end
    end

`ifdef WB_FORWARD_EN
    // Walk oldest-to-youngest from the head so the youngest match overrides.
    always_comb begin
        logic [PTR_W-1:0] idx;
        bus.fwd_hit   = 1'b0;
        bus.fwd_value = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (valid[idx] && entries[idx].addr == bus.fwd_addr) begin
                bus.fwd_hit   = 1'b1;
                bus.fwd_value = entries[idx].value;
            end
        end
    end
`else
    // Forwarding disabled: constant outputs, lookup address and head pointer ignored.
    logic unused_fwd;
    assign unused_fwd    = ^{bus.fwd_addr, rd_ptr};
    assign bus.fwd_hit   = 1'b0;
    assign bus.fwd_value = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue; expectations follow WB_FORWARD_EN when defined.
module tb_writeback_queue;
    import scc_wb_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    // Expected register-file writes: {sel, addr, value_alu, value_id}.
    logic [67:0] exp_q[$];

    writeback_queue_if bus ();

    writeback_queue dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.alu_addr  = '0;
        bus.alu_value = '0;
        bus.id_valid  = 1'b0;
        bus.id_addr   = '0;
        bus.id_value  = '0;
    endtask

    task automatic drive_alu(input logic [2:0] a, input logic [31:0] v);
        bus.alu_valid = 1'b1;
        bus.alu_addr  = a;
        bus.alu_value = v;
    endtask

    task automatic drive_id(input logic [2:0] a, input logic [31:0] v);
        bus.id_valid = 1'b1;
        bus.id_addr  = a;
        bus.id_value = v;
    endtask

    task automatic exp_push(input logic sel, input logic [2:0] a, input logic [31:0] v);
        exp_q.push_back({sel, a, sel ? v : 32'h0, sel ? 32'h0 : v});
    endtask

    // Scoreboard: every register-file write must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.write_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {bus.write_addr, bus.write_value_alu, bus.write_value_id}, 0);
            end else begin
                check("write_port",
                      {bus.write_data_sel, bus.write_addr, bus.write_value_alu, bus.write_value_id},
                      exp_q.pop_front());
            end
        end
    end

    initial begin
        logic exp_hit;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        bus.fwd_addr = '0;
        idle();

        // 1: reset state
        step();
        step();
        check("rst_we", bus.write_enable, 0);
        check("rst_occ", bus.occupancy, 0);
        check("rst_mask", bus.pending_mask, 0);
        check("rst_addr", bus.write_addr, 0);
        check("rst_val_alu", bus.write_value_alu, 0);
        check("rst_val_id", bus.write_value_id, 0);
        check("rst_sel", bus.write_data_sel, 0);
        check("rst_fwd_hit", bus.fwd_hit, 0);
        check("rst_alu_ready", bus.alu_ready, 1);
        check("rst_id_ready", bus.id_ready, 1);
        reset = 1'b1;

        // 2: single ALU push into empty queue
        drive_alu(3'd3, 32'hDEADBEEF);
        exp_push(1'b1, 3'd3, 32'hDEADBEEF);
        step();
        idle();
        check("t2_we", bus.write_enable, 1);
        check("t2_addr", bus.write_addr, 3);
        check("t2_sel", bus.write_data_sel, 1);
        check("t2_val_alu", bus.write_value_alu, 32'hDEADBEEF);
        check("t2_val_id", bus.write_value_id, 0);
        check("t2_mask", bus.pending_mask, 8'h08);
        check("t2_occ", bus.occupancy, 1);
        step();
        check("t2_occ_after", bus.occupancy, 0);
        check("t2_we_after", bus.write_enable, 0);

        // 3: simultaneous ALU and ID to the same register
        drive_alu(3'd1, 32'h11);
        drive_id(3'd1, 32'h22);
        #1;
        check("t3_alu_ready", bus.alu_ready, 1);
        check("t3_id_ready", bus.id_ready, 1);
        exp_push(1'b1, 3'd1, 32'h11);
        exp_push(1'b0, 3'd1, 32'h22);
        step();
        idle();
        check("t3_occ2", bus.occupancy, 2);
        check("t3_sel_first", bus.write_data_sel, 1);
        check("t3_val_first", bus.write_value_alu, 32'h11);
        check("t3_mask_first", bus.pending_mask, 8'h02);
        step();
        check("t3_sel_second", bus.write_data_sel, 0);
        check("t3_val_second", bus.write_value_id, 32'h22);
        check("t3_valalu_second", bus.write_value_alu, 0);
        check("t3_mask_second", bus.pending_mask, 8'h02);
        step();
        check("t3_mask_clear", bus.pending_mask, 0);

        // 4: fill to full, then offer two pushes
        drive_alu(3'd2, 32'h100);
        drive_id(3'd3, 32'h200);
        exp_push(1'b1, 3'd2, 32'h100);
        exp_push(1'b0, 3'd3, 32'h200);
        step();
        check("t4_occ_a", bus.occupancy, 2);
        drive_alu(3'd4, 32'h300);
        drive_id(3'd5, 32'h400);
        #1;
        check("t4_id_ready_b", bus.id_ready, 1);
        exp_push(1'b1, 3'd4, 32'h300);
        exp_push(1'b0, 3'd5, 32'h400);
        step();
        check("t4_occ_b", bus.occupancy, 3);
        drive_alu(3'd6, 32'h500);
        drive_id(3'd7, 32'h600);
        #1;
        check("t4_id_ready_c", bus.id_ready, 1);
        exp_push(1'b1, 3'd6, 32'h500);
        exp_push(1'b0, 3'd7, 32'h600);
        step();
        check("t4_occ_full", bus.occupancy, 4);
        check("t4_mask_full", bus.pending_mask, 8'hF0);
        drive_alu(3'd0, 32'h700);
        drive_id(3'd1, 32'h800);
        #1;
        check("t4_full_alu_ready", bus.alu_ready, 1);
        check("t4_full_id_ready", bus.id_ready, 0);
        exp_push(1'b1, 3'd0, 32'h700);
        step();
        check("t4_occ_d", bus.occupancy, 4);
        bus.alu_valid = 1'b0;
        #1;
        check("t4_id_only_ready", bus.id_ready, 1);
        exp_push(1'b0, 3'd1, 32'h800);
        step();
        idle();
        check("t4_occ_e", bus.occupancy, 4);
        check("t4_mask_e", bus.pending_mask, 8'hC3);
        for (int i = 3; i >= 0; i--) begin
            step();
            check("t4_drain_occ", bus.occupancy, i);
        end

        // 5: reset mid-drain with three entries queued
        drive_alu(3'd1, 32'h1);
        drive_id(3'd2, 32'h2);
        exp_push(1'b1, 3'd1, 32'h1);
        exp_push(1'b0, 3'd2, 32'h2);
        step();
        drive_alu(3'd3, 32'h3);
        drive_id(3'd4, 32'h4);
        exp_push(1'b1, 3'd3, 32'h3);
        exp_push(1'b0, 3'd4, 32'h4);
        step();
        idle();
        check("t5_occ3", bus.occupancy, 3);
        reset = 1'b0;
        exp_q.delete();
        drive_alu(3'd7, 32'h77);
        step();
        idle();
        check("t5_we", bus.write_enable, 0);
        check("t5_occ", bus.occupancy, 0);
        check("t5_mask", bus.pending_mask, 0);
        check("t5_addr", bus.write_addr, 0);
        check("t5_val_alu", bus.write_value_alu, 0);
        reset = 1'b1;
        step();
        check("t5_we_post", bus.write_enable, 0);
        step();
        check("t5_occ_post", bus.occupancy, 0);

        // 6: forwarding lookup, youngest match wins
`ifdef WB_FORWARD_EN
        exp_hit = 1'b1;
`else
        exp_hit = 1'b0;
`endif
        drive_alu(3'd5, 32'hA);
        drive_id(3'd5, 32'hB);
        exp_push(1'b1, 3'd5, 32'hA);
        exp_push(1'b0, 3'd5, 32'hB);
        step();
        idle();
        bus.fwd_addr = 3'd5;
        #1;
        check("t6_hit", bus.fwd_hit, exp_hit);
        check("t6_value", bus.fwd_value, exp_hit ? 32'hB : 32'h0);
        bus.fwd_addr = 3'd6;
        #1;
        check("t6_miss_hit", bus.fwd_hit, 0);
        check("t6_miss_value", bus.fwd_value, 0);
        bus.fwd_addr = 3'd5;
        step();
        check("t6_hit_tail", bus.fwd_hit, exp_hit);
        check("t6_value_tail", bus.fwd_value, exp_hit ? 32'hB : 32'h0);
        step();
        check("t6_hit_empty", bus.fwd_hit, 0);

        step();
        check("all_writes_seen", exp_q.size(), 0);

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
